// File: rtl/seq_mult_16bit.sv
// Sequential 16x16 unsigned shift-add multiplier: one CLA add per cycle, 16 cycles per product.
// Also contains lcu_cla_16bit, the two-level carry-lookahead adder used for accumulation.

module lcu_cla_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        c
);
    logic [15:0] g, p, cbit;
    logic [3:0]  gg, gp;
    logic [4:0]  cg;

    assign g = a & b;
    assign p = a ^ b;

    // Group carries come from the lookahead unit, never rippled between groups
    assign cg[0] = cin;
    assign cg[1] = gg[0] | (gp[0] & cg[0]);
    assign cg[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cg[0]);
    assign cg[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                 | (gp[2] & gp[1] & gp[0] & cg[0]);
    assign cg[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                 | (gp[3] & gp[2] & gp[1] & gg[0])
                 | (gp[3] & gp[2] & gp[1] & gp[0] & cg[0]);
    assign c = cg[4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_group
            localparam int B = gi * 4;
            assign cbit[B]   = cg[gi];
            assign cbit[B+1] = g[B] | (p[B] & cg[gi]);
            assign cbit[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & cg[gi]);
            assign cbit[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                             | (p[B+2] & p[B+1] & p[B] & cg[gi]);
            assign gg[gi] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                          | (p[B+3] & p[B+2] & p[B+1] & g[B]);
            assign gp[gi] = &p[B+3:B];
            assign s[B+3:B] = p[B+3:B] ^ cbit[B+3:B];
        end
    endgenerate
endmodule

module seq_mult_16bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_reg;
    logic [15:0] m_reg, acc_reg, q_reg;
    logic [4:0]  count_reg;
    logic [15:0] add_b, sum;
    logic        carry;

    // Operand gating by mux keeps the adder in the path every cycle
    assign add_b = q_reg[0] ? m_reg : 16'h0000;

    lcu_cla_16bit u_add (
        .a   (acc_reg),
        .b   (add_b),
        .cin (1'b0),
        .s   (sum),
        .c   (carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            product   <= 32'h0;
            m_reg     <= 16'h0;
            acc_reg   <= 16'h0;
            q_reg     <= 16'h0;
            count_reg <= 5'd0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        m_reg     <= a;
                        q_reg     <= b;
                        acc_reg   <= 16'h0;
                        count_reg <= 5'd0;
                        busy      <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    // Carry out becomes ACC[15], so the 32-bit result never overflows
                    acc_reg   <= {carry, sum[15:1]};
                    q_reg     <= {sum[0], q_reg[15:1]};
                    count_reg <= count_reg + 5'd1;
                    if (count_reg == 5'd15) begin
                        product   <= {carry, sum[15:1], sum[0], q_reg[15:1]};
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_mult_16bit.sv
// Self-checking bench for seq_mult_16bit: vector table, random ops vs. a*b, and timing corner cases.

module tb_seq_mult_16bit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = 16'h0, b = 16'h0;
    logic        busy, done;
    logic [31:0] product;

    int n_cmp = 0;
    int n_bad = 0;

    seq_mult_16bit dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one op and wait for done; scramble a/b while running to prove capture
    task automatic do_mult(input logic [15:0] va, input logic [15:0] vb,
                           input logic [31:0] exp, input string name);
        int cycles;
        int busy_low;
        @(negedge clk);
        a = va; b = vb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 0;
        busy_low = 0;
        while (!done && cycles < 40) begin
            if (!busy) busy_low++;
            a = 16'($urandom); b = 16'($urandom);
            @(negedge clk);
            cycles++;
        end
        check({name, " latency"}, 32'(cycles), 32'd16);
        check({name, " busy_during_run"}, 32'(busy_low), 32'd0);
        check({name, " product"}, product, exp);
        check({name, " busy_at_done"}, {31'b0, busy}, 32'd0);
        $display("op %s: a=%h b=%h product=%h cycles=%0d", name, va, vb, product, cycles);
    endtask

    initial begin
        vec_t vt [6];
        logic [15:0] ra, rb;
        int cycles, pulses, bad_prod;

        vt[0] = '{16'h0003, 16'h0005, 32'h0000000F};
        vt[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        vt[2] = '{16'h1234, 16'h5678, 32'h06260060};
        vt[3] = '{16'h8000, 16'h0002, 32'h00010000};
        vt[4] = '{16'h0000, 16'hABCD, 32'h00000000};
        vt[5] = '{16'hABCD, 16'h0000, 32'h00000000};

        #3;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset product", product, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            do_mult(vt[i].a, vt[i].b, vt[i].exp, $sformatf("vec%0d", i));

        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            do_mult(ra, rb, 32'(ra) * 32'(rb), $sformatf("rand%0d", i));
        end

        // start pulsed while busy must be ignored
        @(negedge clk);
        a = 16'd7; b = 16'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 0; pulses = 0;
        repeat (30) begin
            if (cycles == 5) begin a = 16'd100; b = 16'd100; start = 1'b1; end
            else begin start = 1'b0; a = 16'($urandom); b = 16'($urandom); end
            if (done) begin
                pulses++;
                check("ignore_start product", product, 32'h0000003F);
                check("ignore_start latency", 32'(cycles), 32'd16);
            end
            if (cycles > 16) check("ignore_start busy_not_extended", {31'b0, busy}, 32'd0);
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        check("ignore_start pulses", 32'(pulses), 32'd1);
        $display("op ignore_start: pulses=%0d product=%h", pulses, product);

        // back-to-back: second start issued in the done cycle
        do_mult(16'd2, 16'd3, 32'd6, "b2b_first");
        a = 16'd4; b = 16'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 0; bad_prod = 0;
        while (!done && cycles < 40) begin
            if (product !== 32'd6) bad_prod++;
            @(negedge clk);
            cycles++;
        end
        check("b2b second latency", 32'(cycles), 32'd16);
        check("b2b product_held", 32'(bad_prod), 32'd0);
        check("b2b second product", product, 32'd20);
        $display("op b2b_second: a=4 b=5 product=%h cycles=%0d", product, cycles);

        // asynchronous reset mid-run
        @(negedge clk);
        a = 16'h1234; b = 16'h0005; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst busy", {31'b0, busy}, 32'd0);
        check("async_rst done", {31'b0, done}, 32'd0);
        check("async_rst product", product, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        do_mult(16'd10, 16'd10, 32'd100, "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
